pc_add_sequencer: RTL and testbench
===================================

# pc_add_sequencer

Multi-cycle controller that computes a WIDTH-bit sum (a + b + ci) by sequencing a narrow variable-width adder slice, n bits per cycle, from the least-significant chunk upward. It carries the running carry between chunks and assembles the result. It sits in the program-counter path beside the 5-bit carry-select slice and drives that slice through dedicated ports. It implements a start/busy/done handshake for the PC update logic.

## Interface
Parameters:
- WIDTH, 32, operand and result width. Legal range: 5..64.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- cfg_n  in  3  slice width for this operation; legal values 2..5
- a, b  in  WIDTH  operands
- ci  in  1  carry-in
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result valid
- err  out  1  one-cycle pulse; start rejected because cfg_n is illegal
- sum  out  WIDTH  result register
- co  out  1  carry-out register
- sl_n  out  3  width select to slice
- sl_a, sl_b  out  5  chunk operands to slice
- sl_ci  out  1  chunk carry-in to slice
- sl_sum  in  5  slice sum; combinational response within the same cycle
- sl_co  in  1  slice carry-out

## Operation
- Chunk count K = ceil(WIDTH/n). Remainder rem = WIDTH − (K−1)·n, with 1 ≤ rem ≤ n. For WIDTH=32: n=2→K=16, n=3→K=11 (rem 2), n=4→K=8, n=5→K=7 (rem 2).
- FSM states are IDLE, RUN and DONE.
- IDLE transitions:
  - start with cfg_n ∈ {2..5}: latch a, b, ci and n; clear sum and co; idx←0; carry←ci; go to RUN.
  - start with an illegal cfg_n: err=1 for one cycle; stay in IDLE; sum and co unchanged.
- RUN, each cycle:
  - sl_n = latched n.
  - sl_a[i] = a_l[idx·n+i] for i<n when idx·n+i < WIDTH; every other bit is 0. sl_b is formed the same way.
  - sl_ci = carry.
- RUN, at each clock edge:
  - sum[idx·n+i] ← sl_sum[i] for i<n and idx·n+i < WIDTH.
  - If idx<K−1: carry←sl_co, then idx←idx+1.
  - If idx=K−1: co ← (rem==n ? sl_co : sl_sum[rem]), then go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE. start is ignored in DONE.
- start is ignored in RUN. The latched operands are immune to changes on a, b, ci and cfg_n after acceptance.
- In IDLE and DONE, sl_a, sl_b and sl_ci are 0; sl_n holds the last latched n.
- sum and co hold their value from done until the next accepted start.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, sum 0, co 0, sl_* 0, internal idx, carry and n_l all 0.
- reset_n takes effect asynchronously. Asserting it mid-RUN aborts the operation immediately with all outputs at their reset values. Release is synchronous to clk.
- Acceptance happens at edge E0.
- busy is high for K cycles, from E0 to E_K.
- done is high for the cycle between E_K and E_K+1.
- A new start is accepted at E_K+2 at the earliest.
- err is high for the cycle following the edge that sampled the bad start.
- The slice path is combinational within one cycle. There is no pipelining inside the block.

## Test plan
- n=4, a=0xFFFFFFFF, b=0x00000001, ci=0 → done in the 9th cycle after E0; sum=0x00000000, co=1; busy high for exactly 8 cycles.
- n=3, a=0x12345678, b=0x9ABCDEF0, ci=1 → K=11; sum=0xACF13569, co=0. Check that sl_a and sl_b are zero above bit 1 on the last chunk.
- n=5, a=0x80000000, b=0x80000000, ci=0 → K=7; sum=0x00000000, co=1 (taken from sl_sum[2], not sl_co).
- cfg_n=6 or cfg_n=1 with start → err pulses once, busy stays 0, and sum and co keep their previous values (e.g. 0xACF13569/0).
- n=2 operation; toggle a, b and start during RUN, then pull reset_n low at idx=5 → all outputs go to 0 immediately. A following n=2 start with a=3, b=4, ci=0 gives sum=7, co=0 after 16 RUN cycles.
- start held high continuously with n=4 → operations are accepted back-to-back every 10 cycles, with no acceptance in RUN or DONE, and done pulses exactly once per operation.

Source files
------------

// File: rtl/pc_add_sequencer.sv
// Computes a + b + ci by driving an external narrow adder slice n bits per cycle, LSB chunk first.
// Latency ceil(WIDTH/n) RUN cycles plus one DONE cycle; start is only sampled in IDLE.
module pc_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       cfg_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic [2:0]       sl_n,
    output logic [4:0]       sl_a,
    output logic [4:0]       sl_b,
    output logic             sl_ci,
    input  logic [4:0]       sl_sum,
    input  logic             sl_co
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [2:0]       n_q, n_d;
    logic [5:0]       idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             err_q, err_d;

    logic [6:0]       base;
    logic [6:0]       rem;
    logic [4:0]       nmask;
    logic [WIDTH-1:0] ins_mask;
    logic [WIDTH-1:0] ins_val;
    logic             last;
    logic             cfg_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        base     = 7'(idx_q) * 7'(n_q);
        rem      = 7'(WIDTH) - base;
        nmask    = 5'((6'd1 << n_q) - 6'd1);
        // Shifting past WIDTH zero-fills, so bits beyond the operand top come out as 0.
        ins_mask = WIDTH'(nmask) << base;
        ins_val  = WIDTH'(sl_sum & nmask) << base;
        last     = (8'(base) + 8'(n_q)) >= 8'(WIDTH);
        cfg_ok   = (cfg_n >= 3'd2) && (cfg_n <= 3'd5);

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        n_d      = n_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        co_d     = co_q;
        err_d    = 1'b0;
        sl_a     = '0;
        sl_b     = '0;
        sl_ci    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        a_d     = a;
                        b_d     = b;
                        n_d     = cfg_n;
                        carry_d = ci;
                        idx_d   = '0;
                        sum_d   = '0;
                        co_d    = 1'b0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                sl_a  = 5'(a_q >> base) & nmask;
                sl_b  = 5'(b_q >> base) & nmask;
                sl_ci = carry_q;
                sum_d = (sum_q & ~ins_mask) | ins_val;
                if (last) begin
                    // A short final chunk leaves its carry in the first unused sum bit.
                    co_d    = (rem == 7'(n_q)) ? sl_co : sl_sum[rem[2:0]];
                    state_d = DONE;
                end else begin
                    carry_d = sl_co;
                    idx_d   = idx_q + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign err  = err_q;
    assign sum  = sum_q;
    assign co   = co_q;
    assign sl_n = n_q;

endmodule

// File: tb/tb_pc_add_sequencer.sv
// Random and directed operations against a plain a+b+ci model, with a done-driven scoreboard.
module tb_pc_add_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   cfg_n = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy, done, err, co, sl_ci, sl_co;
    logic [W-1:0] sum;
    logic [2:0]   sl_n;
    logic [4:0]   sl_a, sl_b, sl_sum;

    logic [5:0]   sl_full;
    logic [4:0]   sl_m;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           pushes = 0;
    int           done_seen = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_co = 1'b0;

    pc_add_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_n(cfg_n),
        .a(a), .b(b), .ci(ci), .busy(busy), .done(done), .err(err),
        .sum(sum), .co(co), .sl_n(sl_n), .sl_a(sl_a), .sl_b(sl_b),
        .sl_ci(sl_ci), .sl_sum(sl_sum), .sl_co(sl_co)
    );

    always #5 clk = ~clk;

    // Behavioural n-bit adder slice: sum masked to n bits, carry is bit n.
    always_comb begin
        sl_full = 6'(sl_a) + 6'(sl_b) + 6'(sl_ci);
        sl_m    = 5'((6'd1 << sl_n) - 6'd1);
        sl_sum  = sl_full[4:0] & sl_m;
        sl_co   = sl_full[sl_n];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] t;
        exp_t e;
        t = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
        e.s = t[W-1:0];
        e.c = t[W];
        sb.push_back(e);
        last_sum = e.s;
        last_co  = e.c;
        pushes++;
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
                e = sb.pop_front();
                chk("sum", sum, e.s);
                chk("co", co, e.c);
            end
        end
    end

    task automatic run_op(input int n, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input bit toggle);
        int k, rem, bc;
        bit got;
        k   = (W + n - 1) / n;
        rem = W - (k - 1) * n;
        @(negedge clk);
        start = 1'b1; cfg_n = 3'(n); a = av; b = bv; ci = cv;
        push(av, bv, cv);
        @(negedge clk);
        start = 1'b0;
        bc  = 0;
        got = 1'b0;
        for (int w = 1; w <= 80 && !got; w++) begin
            if (w > 1) @(negedge clk);
            if (busy) begin
                bc++;
                if (bc == 1) chk("sl_n", sl_n, n);
                if (bc == k) begin
                    chk("last_sl_a_hi", sl_a >> rem, 0);
                    chk("last_sl_b_hi", sl_b >> rem, 0);
                end
            end
            if (done) begin
                got = 1'b1;
                chk("done_latency", w, k + 1);
                start = 1'b0;
            end else if (toggle && busy) begin
                a = $urandom; b = $urandom; ci = 1'($urandom);
                cfg_n = 3'($urandom); start = 1'($urandom);
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        chk("busy_cycles", bc, k);
        start = 1'b0;
    endtask

    task automatic err_op(input logic [2:0] cfg);
        @(negedge clk);
        start = 1'b1; cfg_n = cfg; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_cleared", err, 0);
        chk("err_busy2", busy, 0);
        chk("err_sum_kept", sum, last_sum);
        chk("err_co_kept", co, last_co);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_co"}, co, 0);
        chk({tag, "_sl_n"}, sl_n, 0);
        chk({tag, "_sl_a"}, sl_a, 0);
        chk({tag, "_sl_b"}, sl_b, 0);
        chk({tag, "_sl_ci"}, sl_ci, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        run_op(4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(3, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
        chk("t2_sum_const", sum, 32'hACF13569);
        chk("t2_co_const", co, 0);
        err_op(3'd6);
        err_op(3'd1);
        err_op(3'd0);
        err_op(3'd7);
        run_op(5, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        chk("t3_co_const", co, 1);

        // Abort an n=2 operation at idx 5 with reset.
        @(negedge clk);
        start = 1'b1; cfg_n = 3'd2; a = $urandom; b = $urandom; ci = 1'b1;
        push(a, b, ci);
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int w = 0; w < 20 && bc < 6; w++) begin
            if (w > 0) @(negedge clk);
            if (busy) bc++;
            if (bc < 6) begin
                a = $urandom; b = $urandom; start = 1'($urandom);
            end
        end
        chk("abort_reached_idx5", bc, 6);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        void'(sb.pop_back());
        pushes--;
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;
        run_op(2, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("after_abort_sum", sum, 7);
        chk("after_abort_co", co, 0);

        for (int r = 0; r < 10; r++)
            run_op(int'($urandom_range(2, 5)), $urandom, $urandom, 1'($urandom), 1'b1);

        // Start held high with n=4: acceptance every 10 cycles.
        @(negedge clk);
        start = 1'b1; cfg_n = 3'd4; a = $urandom; b = $urandom; ci = 1'($urandom);
        push(a, b, ci);
        for (int t = 1; t <= 30; t++) begin
            int p;
            @(negedge clk);
            p = (t - 1) % 10;
            chk("b2b_busy", busy, (p < 8) ? 1 : 0);
            chk("b2b_done", done, (p == 8) ? 1 : 0);
            if (p == 9) begin
                if (t < 30) begin
                    a = $urandom; b = $urandom; ci = 1'($urandom);
                    push(a, b, ci);
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = $urandom; b = $urandom; ci = 1'($urandom);
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", done_seen, pushes);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
